// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder and the event packer:
// event codes, ASCII constants, FSM state encodings and byte classifiers.
package uart_cmd_decoder_pkg;

    typedef enum logic [3:0] {
        EVT_NONE  = 4'd0,
        EVT_START = 4'd1,
        EVT_STOP  = 4'd2,
        EVT_CLEAR = 4'd3,
        EVT_SAVE  = 4'd4,
        EVT_TIME  = 4'd5,
        EVT_SR04  = 4'd6,
        EVT_DHT11 = 4'd7
    } evt_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_DIGITS  = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_S     = 8'h53;
    localparam logic [7:0] CH_C     = 8'h43;
    localparam logic [7:0] CH_V     = 8'h56;
    localparam logic [7:0] CH_T     = 8'h54;
    localparam logic [7:0] CH_U     = 8'h55;
    localparam logic [7:0] CH_H     = 8'h48;

    localparam int unsigned SET_DIGITS = 6;

    // Clearing bit 5 folds lowercase letters onto uppercase; no other byte lands on a command letter.
    function automatic evt_e letter_to_evt(input logic [7:0] b);
        case (b & 8'hDF)
            CH_R:    return EVT_START;
            CH_S:    return EVT_STOP;
            CH_C:    return EVT_CLEAR;
            CH_V:    return EVT_SAVE;
            CH_T:    return EVT_TIME;
            CH_U:    return EVT_SR04;
            CH_H:    return EVT_DHT11;
            default: return EVT_NONE;
        endcase
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_bcd2_to_bin.sv
// Two BCD digits to binary with an upper-bound range flag.
module bcd2_to_bin #(
    parameter int unsigned OUT_W   = 6,
    parameter int unsigned MAX_VAL = 59
) (
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic [OUT_W-1:0] value_c,
    output logic             in_range_c
);

    logic [7:0] full;

    // tens*10 + ones, range-checked at full width before truncation
    always_comb begin
        full       = 8'(tens) * 8'd10 + 8'(ones);
        in_range_c = (full <= 8'(MAX_VAL));
        value_c    = OUT_W'(full);
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII command-line parser on the UART RX byte stream. Each accepted line
// fires one registered trigger pulse; malformed lines and timeouts pulse o_err.
// Optional feature macro: WATCH_SET_EN enables "T hhmmss" watch setting.
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       o_sw_start_trig,
    output logic       o_sw_stop_trig,
    output logic       o_sw_clear_trig,
    output logic       o_sw_save_trig,
    output logic       o_w_time_trig,
    output logic       o_sr04_trig,
    output logic       o_dht11_trig,
    output logic [3:0] o_evt,
    output logic       o_err,
    output logic       o_set_valid,
    output logic [4:0] o_set_hour,
    output logic [5:0] o_set_min,
    output logic [5:0] o_set_sec
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e           state;
    state_e           eff_state;
    evt_e             pend_evt;
    evt_e             letter_evt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             term_c;

    // A timeout takes precedence: a byte arriving on that cycle is parsed from IDLE.
    assign tmo_hit    = (state != ST_IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign eff_state  = tmo_hit ? ST_IDLE : state;
    assign letter_evt = letter_to_evt(rx_data);
    assign term_c     = is_term(rx_data);

`ifdef WATCH_SET_EN
    logic [23:0] dig_buf;
    logic [2:0]  dig_cnt;
    logic        digit_c;
    logic [4:0]  hour_v;
    logic [5:0]  min_v;
    logic [5:0]  sec_v;
    logic        hour_ok;
    logic        min_ok;
    logic        sec_ok;
    logic        fields_ok;

    assign digit_c   = is_digit(rx_data);
    assign fields_ok = (dig_cnt == 3'(SET_DIGITS)) && hour_ok && min_ok && sec_ok;

    bcd2_to_bin #(.OUT_W(5), .MAX_VAL(23)) u_hour (
        .tens(dig_buf[23:20]), .ones(dig_buf[19:16]), .value_c(hour_v), .in_range_c(hour_ok));
    bcd2_to_bin #(.OUT_W(6), .MAX_VAL(59)) u_min (
        .tens(dig_buf[15:12]), .ones(dig_buf[11:8]), .value_c(min_v), .in_range_c(min_ok));
    bcd2_to_bin #(.OUT_W(6), .MAX_VAL(59)) u_sec (
        .tens(dig_buf[7:4]), .ones(dig_buf[3:0]), .value_c(sec_v), .in_range_c(sec_ok));
`else
    assign o_set_valid = 1'b0;
    assign o_set_hour  = '0;
    assign o_set_min   = '0;
    assign o_set_sec   = '0;
`endif

    // Line parser FSM with inter-byte timeout and registered pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            pend_evt        <= EVT_NONE;
            tmo_cnt         <= '0;
            o_sw_start_trig <= 1'b0;
            o_sw_stop_trig  <= 1'b0;
            o_sw_clear_trig <= 1'b0;
            o_sw_save_trig  <= 1'b0;
            o_w_time_trig   <= 1'b0;
            o_sr04_trig     <= 1'b0;
            o_dht11_trig    <= 1'b0;
            o_evt           <= 4'd0;
            o_err           <= 1'b0;
`ifdef WATCH_SET_EN
            dig_buf         <= '0;
            dig_cnt         <= '0;
            o_set_valid     <= 1'b0;
            o_set_hour      <= '0;
            o_set_min       <= '0;
            o_set_sec       <= '0;
`endif
        end else begin
            o_sw_start_trig <= 1'b0;
            o_sw_stop_trig  <= 1'b0;
            o_sw_clear_trig <= 1'b0;
            o_sw_save_trig  <= 1'b0;
            o_w_time_trig   <= 1'b0;
            o_sr04_trig     <= 1'b0;
            o_dht11_trig    <= 1'b0;
            o_err           <= 1'b0;
`ifdef WATCH_SET_EN
            o_set_valid     <= 1'b0;
`endif

            if (rx_valid || tmo_hit || (state == ST_IDLE)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end

            if (tmo_hit) begin
                o_err <= 1'b1;
                state <= ST_IDLE;
`ifdef WATCH_SET_EN
                dig_cnt <= '0;
`endif
            end

            if (rx_valid) begin
                case (eff_state)
                    ST_IDLE: begin
                        if (!term_c) begin
                            if (letter_evt != EVT_NONE) begin
                                pend_evt <= letter_evt;
                                state    <= ST_CMD;
                            end else begin
                                state <= ST_DISCARD;
                            end
                        end
                    end
                    ST_CMD: begin
                        if (term_c) begin
                            o_evt <= pend_evt;
                            state <= ST_IDLE;
                            case (pend_evt)
                                EVT_START: o_sw_start_trig <= 1'b1;
                                EVT_STOP:  o_sw_stop_trig  <= 1'b1;
                                EVT_CLEAR: o_sw_clear_trig <= 1'b1;
                                EVT_SAVE:  o_sw_save_trig  <= 1'b1;
                                EVT_TIME:  o_w_time_trig   <= 1'b1;
                                EVT_SR04:  o_sr04_trig     <= 1'b1;
                                EVT_DHT11: o_dht11_trig    <= 1'b1;
                                default:   o_err           <= 1'b1;
                            endcase
`ifdef WATCH_SET_EN
                        end else if (digit_c && (pend_evt == EVT_TIME)) begin
                            dig_buf <= {dig_buf[19:0], rx_data[3:0]};
                            dig_cnt <= 3'd1;
                            state   <= ST_DIGITS;
`endif
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end
`ifdef WATCH_SET_EN
                    ST_DIGITS: begin
                        if (term_c) begin
                            state <= ST_IDLE;
                            if (fields_ok) begin
                                o_set_valid <= 1'b1;
                                o_set_hour  <= hour_v;
                                o_set_min   <= min_v;
                                o_set_sec   <= sec_v;
                            end else begin
                                o_err <= 1'b1;
                            end
                        end else if (digit_c && (dig_cnt < 3'(SET_DIGITS))) begin
                            dig_buf <= {dig_buf[19:0], rx_data[3:0]};
                            dig_cnt <= dig_cnt + 3'd1;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end
`endif
                    ST_DISCARD: begin
                        if (term_c) begin
                            o_err <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: a line-level reference model,
// a per-cycle compare process, directed scenarios and randomized byte streams.
`timescale 1ns/1ps
module tb_uart_cmd_decoder;

    localparam int unsigned T = 50;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       o_sw_start_trig, o_sw_stop_trig, o_sw_clear_trig, o_sw_save_trig;
    logic       o_w_time_trig, o_sr04_trig, o_dht11_trig, o_err, o_set_valid;
    logic [3:0] o_evt;
    logic [4:0] o_set_hour;
    logic [5:0] o_set_min, o_set_sec;

    always #5 clk = ~clk;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .o_sw_start_trig(o_sw_start_trig), .o_sw_stop_trig(o_sw_stop_trig),
        .o_sw_clear_trig(o_sw_clear_trig), .o_sw_save_trig(o_sw_save_trig),
        .o_w_time_trig(o_w_time_trig), .o_sr04_trig(o_sr04_trig),
        .o_dht11_trig(o_dht11_trig), .o_evt(o_evt), .o_err(o_err),
        .o_set_valid(o_set_valid), .o_set_hour(o_set_hour),
        .o_set_min(o_set_min), .o_set_sec(o_set_sec)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (works on whole lines) ----------------
    logic [6:0] exp_trig = '0;
    logic [3:0] exp_evt = '0;
    logic       exp_err = 1'b0;
    logic       exp_set_valid = 1'b0;
    logic [4:0] exp_hour = '0;
    logic [5:0] exp_min = '0;
    logic [5:0] exp_sec = '0;
    logic [7:0] line_q[$];
    longint     cyc = 0;
    longint     last_cyc = 0;

    function automatic int letter_code(input logic [7:0] b);
        case (b)
            "R", "r": return 1;
            "S", "s": return 2;
            "C", "c": return 3;
            "V", "v": return 4;
            "T", "t": return 5;
            "U", "u": return 6;
            "H", "h": return 7;
            default:  return 0;
        endcase
    endfunction

    function automatic bit is_dig(input logic [7:0] b);
        return (b >= "0") && (b <= "9");
    endfunction

    task automatic finish_line();
        int code;
        code = letter_code(line_q[0]);
        if (line_q.size() == 1 && code != 0) begin
            exp_evt = 4'(code);
            exp_trig[code-1] = 1'b1;
        end
`ifdef WATCH_SET_EN
        else if (line_q.size() == 7 && code == 5 && is_dig(line_q[1]) && is_dig(line_q[2]) &&
                 is_dig(line_q[3]) && is_dig(line_q[4]) && is_dig(line_q[5]) && is_dig(line_q[6])) begin
            int h, m, s;
            h = (int'(line_q[1]) - 48) * 10 + (int'(line_q[2]) - 48);
            m = (int'(line_q[3]) - 48) * 10 + (int'(line_q[4]) - 48);
            s = (int'(line_q[5]) - 48) * 10 + (int'(line_q[6]) - 48);
            if (h <= 23 && m <= 59 && s <= 59) begin
                exp_set_valid = 1'b1;
                exp_hour = 5'(h);
                exp_min  = 6'(m);
                exp_sec  = 6'(s);
            end else begin
                exp_err = 1'b1;
            end
        end
`endif
        else begin
            exp_err = 1'b1;
        end
        line_q.delete();
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_trig = '0; exp_evt = '0; exp_err = 1'b0; exp_set_valid = 1'b0;
                exp_hour = '0; exp_min = '0; exp_sec = '0;
                line_q.delete();
            end else begin
                cyc++;
                exp_trig = '0; exp_err = 1'b0; exp_set_valid = 1'b0;
                if (line_q.size() > 0 && (cyc - last_cyc) == longint'(T)) begin
                    exp_err = 1'b1;
                    line_q.delete();
                end
                if (rx_valid) begin
                    last_cyc = cyc;
                    if (rx_data == CR || rx_data == LF) begin
                        if (line_q.size() > 0) finish_line();
                    end else if (line_q.size() < 16) begin
                        line_q.push_back(rx_data);
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("start", 8'(o_sw_start_trig), 8'(exp_trig[0]));
        check("stop",  8'(o_sw_stop_trig),  8'(exp_trig[1]));
        check("clear", 8'(o_sw_clear_trig), 8'(exp_trig[2]));
        check("save",  8'(o_sw_save_trig),  8'(exp_trig[3]));
        check("time",  8'(o_w_time_trig),   8'(exp_trig[4]));
        check("sr04",  8'(o_sr04_trig),     8'(exp_trig[5]));
        check("dht11", 8'(o_dht11_trig),    8'(exp_trig[6]));
        check("evt",   8'(o_evt),           8'(exp_evt));
        check("err",   8'(o_err),           8'(exp_err));
        check("set_valid", 8'(o_set_valid), 8'(exp_set_valid));
        check("set_hour",  8'(o_set_hour),  8'(exp_hour));
        check("set_min",   8'(o_set_min),   8'(exp_min));
        check("set_sec",   8'(o_set_sec),   8'(exp_sec));
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        repeat (gap) step();
    endtask

    function automatic int rand_gap();
        if ($urandom_range(0, 19) == 0) return int'(T) - 3 + int'($urandom_range(0, 4));
        return int'($urandom_range(0, 2));
    endfunction

    function automatic logic [7:0] rand_term();
        return ($urandom_range(0, 1) == 1) ? CR : LF;
    endfunction

    task automatic send_digits(input int v, input int gap);
        send(8'(48 + v / 10), gap);
        send(8'(48 + v % 10), gap);
    endtask

    task automatic rand_line();
        string letters = "RSCVTUHrscvtuh";
        string junk    = "RrTt0159Xa :";
        int    kind    = int'($urandom_range(0, 9));
        case (kind)
            0, 1, 2, 3: begin
                send(8'(letters[$urandom_range(0, 13)]), rand_gap());
                send(rand_term(), rand_gap());
                if ($urandom_range(0, 2) == 0) send(LF, rand_gap());
            end
            4, 5: begin
                send(($urandom_range(0, 1) == 1) ? "T" : "t", rand_gap());
                send_digits(int'($urandom_range(0, 26)), rand_gap());
                send_digits(int'($urandom_range(0, 62)), rand_gap());
                send_digits(int'($urandom_range(0, 62)), rand_gap());
                if ($urandom_range(0, 5) == 0) send("7", 0);
                send(rand_term(), rand_gap());
            end
            6, 7: begin
                repeat ($urandom_range(1, 5)) begin
                    if ($urandom_range(0, 4) == 0) send(8'($urandom_range(0, 255)), rand_gap());
                    else send(8'(junk[$urandom_range(0, 11)]), rand_gap());
                end
                send(rand_term(), rand_gap());
            end
            8: begin
                send(8'(letters[$urandom_range(0, 13)]), 0);
                repeat (int'(T) - 2 + int'($urandom_range(0, 3))) step();
            end
            default: begin
                send("T", 0);
                send("1", 0);
                rst = 1'b1;
                step();
                rst = 1'b0;
                step();
            end
        endcase
    endtask

    // ---------------- directed scenarios, then random ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_evt", 8'(o_evt), 8'd0);
        check("rst_err", 8'(o_err), 8'd0);
        rst = 1'b0;
        step();

        send("R", 0); send(CR, 0);
        check("t1_start", 8'(o_sw_start_trig), 8'd1);
        check("t1_evt", 8'(o_evt), 8'd1);
        check("t1_model_evt", 8'(exp_evt), 8'd1);
        send(LF, 0);
        check("t1_lf_start", 8'(o_sw_start_trig), 8'd0);
        check("t1_lf_err", 8'(o_err), 8'd0);
        step();

        send("s", 0); send(CR, 0);
        check("t2_stop", 8'(o_sw_stop_trig), 8'd1);
        check("t2_evt", 8'(o_evt), 8'd2);
        send("c", 1); send(LF, 0);
        check("t2_clear", 8'(o_sw_clear_trig), 8'd1);
        check("t2_evt2", 8'(o_evt), 8'd3);

        send("X", 0); send(CR, 0);
        check("t3_err_x", 8'(o_err), 8'd1);
        check("t3_model_err", 8'(exp_err), 8'd1);
        send("R", 0); send("R", 0); send(CR, 0);
        check("t3_err_rr", 8'(o_err), 8'd1);
        check("t3_no_start", 8'(o_sw_start_trig), 8'd0);
        check("t3_evt_held", 8'(o_evt), 8'd3);

        send("T", 0);
        send_digits(12, 0); send_digits(34, 0); send_digits(56, 0);
        send(CR, 0);
`ifdef WATCH_SET_EN
        check("t4_set_valid", 8'(o_set_valid), 8'd1);
        check("t4_hour", 8'(o_set_hour), 8'd12);
        check("t4_min", 8'(o_set_min), 8'd34);
        check("t4_sec", 8'(o_set_sec), 8'd56);
        send("T", 0);
        send_digits(24, 0); send_digits(60, 0); send_digits(0, 0);
        send(CR, 0);
        check("t4_bad_err", 8'(o_err), 8'd1);
        check("t4_hour_held", 8'(o_set_hour), 8'd12);
`else
        check("t4_err", 8'(o_err), 8'd1);
        check("t4_no_set", 8'(o_set_valid), 8'd0);
        check("t4_no_time", 8'(o_w_time_trig), 8'd0);
`endif

        send("U", 0);
        repeat (int'(T) - 1) step();
        check("t5_err_early", 8'(o_err), 8'd0);
        step();
        check("t5_timeout_err", 8'(o_err), 8'd1);
        check("t5_model_err", 8'(exp_err), 8'd1);
        check("t5_no_sr04", 8'(o_sr04_trig), 8'd0);
        send("H", 0); send(CR, 0);
        check("t5_dht11", 8'(o_dht11_trig), 8'd1);
        check("t5_evt", 8'(o_evt), 8'd7);

        send("T", 0); send("1", 0); send("2", 0);
        rst = 1'b1;
        step();
        check("t6_rst_evt", 8'(o_evt), 8'd0);
        check("t6_rst_err", 8'(o_err), 8'd0);
        rst = 1'b0;
        step();
        check("t6_post_err", 8'(o_err), 8'd0);
        send("V", 0); send(CR, 0);
        check("t6_save", 8'(o_sw_save_trig), 8'd1);
        check("t6_evt", 8'(o_evt), 8'd4);
        check("t6_model_evt", 8'(exp_evt), 8'd4);

        repeat (200) rand_line();
        repeat (int'(T) + 5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
